// File: rtl/fnorm_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : fnorm_arbiter_if
//  Brief    : Request, normalizer and result bundle for fnorm_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface fnorm_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int EW1   = 10,
    parameter int FW1   = 26,
    parameter int EW2   = 8,
    parameter int FW2   = 23,
    parameter int TAG_W = 4
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ*3-1:0]       req_rm;
    logic [N_REQ*TAG_W-1:0]   req_tag;
    logic [N_REQ*EW1-1:0]     req_exp;
    logic [N_REQ*(FW1+1)-1:0] req_sig;
    logic [N_REQ-1:0]         req_sign;
    logic [N_REQ-1:0]         req_inf;
    logic [N_REQ-1:0]         req_nan;
    logic [N_REQ-1:0]         req_zero;

    logic [2:0]               norm_rm;
    logic [EW1-1:0]           norm_exp;
    logic [FW1:0]             norm_sig;
    logic                     norm_sign;
    logic                     norm_inf;
    logic                     norm_nan;
    logic                     norm_zero;

    logic [EW2-1:0]           norm_res_exp;
    logic [FW2:0]             norm_res_sig;
    logic                     norm_res_sign;
    logic                     norm_res_inf;
    logic                     norm_res_nan;
    logic                     norm_res_zero;

    logic                     out_valid;
    logic                     out_ready;
    logic [ID_W-1:0]          out_id;
    logic [TAG_W-1:0]         out_tag;
    logic [EW2-1:0]           out_exp;
    logic [FW2:0]             out_sig;
    logic                     out_sign;
    logic                     out_inf;
    logic                     out_nan;
    logic                     out_zero;

    modport slave (
        input  req_valid, req_rm, req_tag, req_exp, req_sig,
               req_sign, req_inf, req_nan, req_zero,
        output req_ready,
        output norm_rm, norm_exp, norm_sig, norm_sign, norm_inf, norm_nan, norm_zero,
        input  norm_res_exp, norm_res_sig, norm_res_sign,
               norm_res_inf, norm_res_nan, norm_res_zero,
        output out_valid, out_id, out_tag, out_exp, out_sig,
               out_sign, out_inf, out_nan, out_zero,
        input  out_ready
    );

    modport master (
        output req_valid, req_rm, req_tag, req_exp, req_sig,
               req_sign, req_inf, req_nan, req_zero,
        input  req_ready,
        input  norm_rm, norm_exp, norm_sig, norm_sign, norm_inf, norm_nan, norm_zero,
        output norm_res_exp, norm_res_sig, norm_res_sign,
               norm_res_inf, norm_res_nan, norm_res_zero,
        input  out_valid, out_id, out_tag, out_exp, out_sig,
               out_sign, out_inf, out_nan, out_zero,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/fnorm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fnorm_arbiter
//  Brief    : Shares one 1-cycle FP normalizer among N_REQ requesters and
//             returns results in grant order through a 2-entry FIFO.
//             FNORM_ARB_FIXED_PRIO_EN selects fixed priority instead of RR.
//  Revision : 1.0  initial release
// ============================================================================
module fnorm_arbiter #(
    parameter int N_REQ = 3,
    parameter int EW1   = 10,
    parameter int FW1   = 26,
    parameter int EW2   = 8,
    parameter int FW2   = 23,
    parameter int TAG_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    fnorm_arbiter_if.slave bus
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int IW   = ID_W + 1;
    localparam int DW   = ID_W + TAG_W + EW2 + (FW2 + 1) + 4;

    logic [2:0]       w_rm  [N_REQ];
    logic [TAG_W-1:0] w_tag [N_REQ];
    logic [EW1-1:0]   w_exp [N_REQ];
    logic [FW1:0]     w_sig [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_rm[gi]  = bus.req_rm[gi*3 +: 3];
        assign w_tag[gi] = bus.req_tag[gi*TAG_W +: TAG_W];
        assign w_exp[gi] = bus.req_exp[gi*EW1 +: EW1];
        assign w_sig[gi] = bus.req_sig[gi*(FW1+1) +: (FW1+1)];
    end

    logic             r_inflight;
    logic [ID_W-1:0]  r_if_id;
    logic [TAG_W-1:0] r_if_tag;
    logic [DW-1:0]    r_mem [2];
    logic             r_rd;
    logic             r_wr;
    logic [1:0]       r_count;

    logic             w_pop;
    logic             w_push;
    logic [2:0]       w_credit;
    logic             w_can_grant;
    logic             w_gnt;
    logic [ID_W-1:0]  w_gnt_id;
    logic [DW-1:0]    w_push_data;

    assign w_pop       = (r_count != 2'd0) & bus.out_ready;
    assign w_push      = r_inflight & ~flush;
    // Credit counts slots already promised: stored, in the normalizer, minus what leaves now.
    assign w_credit    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_can_grant = ~flush & (w_credit < 3'd2);

`ifndef FNORM_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0] r_ptr;
    logic [IW-1:0]   w_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_gnt) begin
            r_ptr <= (w_gnt_id == ID_W'(N_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
        end
    end
`endif

    // Scan downward so the last hit, i.e. the first in priority order, wins.
    always_comb begin
        w_gnt    = 1'b0;
        w_gnt_id = '0;
`ifdef FNORM_ARB_FIXED_PRIO_EN
        if (w_can_grant) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (bus.req_valid[i]) begin
                    w_gnt    = 1'b1;
                    w_gnt_id = ID_W'(i);
                end
            end
        end
`else
        w_idx = '0;
        if (w_can_grant) begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                w_idx = {1'b0, r_ptr} + IW'(k);
                if (w_idx >= IW'(N_REQ)) begin
                    w_idx = w_idx - IW'(N_REQ);
                end
                if (bus.req_valid[w_idx[ID_W-1:0]]) begin
                    w_gnt    = 1'b1;
                    w_gnt_id = w_idx[ID_W-1:0];
                end
            end
        end
`endif
    end

    always_comb begin
        bus.req_ready = '0;
        bus.norm_rm   = '0;
        bus.norm_exp  = '0;
        bus.norm_sig  = '0;
        bus.norm_sign = 1'b0;
        bus.norm_inf  = 1'b0;
        bus.norm_nan  = 1'b0;
        bus.norm_zero = 1'b0;
        if (w_gnt) begin
            bus.req_ready[w_gnt_id] = 1'b1;
            bus.norm_rm   = w_rm[w_gnt_id];
            bus.norm_exp  = w_exp[w_gnt_id];
            bus.norm_sig  = w_sig[w_gnt_id];
            bus.norm_sign = bus.req_sign[w_gnt_id];
            bus.norm_inf  = bus.req_inf[w_gnt_id];
            bus.norm_nan  = bus.req_nan[w_gnt_id];
            bus.norm_zero = bus.req_zero[w_gnt_id];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_if_id    <= '0;
            r_if_tag   <= '0;
        end else begin
            r_inflight <= w_gnt;
            if (w_gnt) begin
                r_if_id  <= w_gnt_id;
                r_if_tag <= w_tag[w_gnt_id];
            end
        end
    end

    assign w_push_data = {r_if_id, r_if_tag, bus.norm_res_exp, bus.norm_res_sig,
                          bus.norm_res_sign, bus.norm_res_inf, bus.norm_res_nan,
                          bus.norm_res_zero};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_count <= '0;
        end else if (flush) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= w_push_data;
                r_wr        <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign bus.out_valid = (r_count != 2'd0);
    assign {bus.out_id, bus.out_tag, bus.out_exp, bus.out_sig,
            bus.out_sign, bus.out_inf, bus.out_nan, bus.out_zero} = r_mem[r_rd];
endmodule
`default_nettype wire
